// File: rtl/triangle_search.sv
// -----------------------------------------------------------------------------
// triangle_search
// Walks the triangle numbers T(n) = 1, 3, 6, 10, ... and hands each one to an
// external divisor counter. The walk stops at the first T(n) whose divisor
// count is strictly greater than a latched threshold. If the next T(n) does
// not fit in WIDTH bits, the walk stops instead with overflow set.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst_n        in   1      synchronous active-low reset, wins over go
//   go           in   1      start request, accepted only in IDLE/DONE/OVF
//   threshold    in   WIDTH  divisor-count bound, latched on accepted go
//   fc_start     out  1      one-cycle start pulse to the divisor counter
//   fc_value     out  WIDTH  triangle number under test
//   fc_done      in   1      divisor counter completion level
//   fc_result    in   WIDTH  divisor count, valid while fc_done=1
//   busy         out  1      search in progress
//   found        out  1      level, result available
//   found_value  out  WIDTH  winning (or last tested, on overflow) T(n)
//   found_index  out  WIDTH  winning (or last tested, on overflow) n
//   overflow     out  1      level, T(n+1) would not fit in WIDTH bits
// -----------------------------------------------------------------------------
module triangle_search #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [WIDTH-1:0] threshold,
    output logic             fc_start,
    output logic [WIDTH-1:0] fc_value,
    input  logic             fc_done,
    input  logic [WIDTH-1:0] fc_result,
    output logic             busy,
    output logic             found,
    output logic [WIDTH-1:0] found_value,
    output logic [WIDTH-1:0] found_index,
    output logic             overflow
);

    localparam int unsigned SUM_W = WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEXT,
        S_ISSUE,
        S_ACK,
        S_WAIT,
        S_CHECK,
        S_DONE,
        S_OVF
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_n;
    logic [WIDTH-1:0]   r_t;
    logic [WIDTH-1:0]   r_thr;
    logic [WIDTH-1:0]   r_count;
    logic               r_fc_start;
    logic               r_busy;
    logic               r_found;
    logic [WIDTH-1:0]   r_found_value;
    logic [WIDTH-1:0]   r_found_index;
    logic               r_overflow;

    // Next triangle number with one extra bit; the top bit flags overflow.
    logic [SUM_W-1:0]   w_t_sum;
    logic [WIDTH-1:0]   w_n_inc;

    assign w_n_inc = r_n + WIDTH'(1);
    assign w_t_sum = {1'b0, r_t} + {1'b0, r_n} + SUM_W'(1);

    // Search controller: all state and outputs update here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_n           <= '0;
            r_t           <= '0;
            r_thr         <= '0;
            r_count       <= '0;
            r_fc_start    <= 1'b0;
            r_busy        <= 1'b0;
            r_found       <= 1'b0;
            r_found_value <= '0;
            r_found_index <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_fc_start <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_OVF: begin
                    if (go) begin
                        r_thr         <= threshold;
                        r_n           <= '0;
                        r_t           <= '0;
                        r_found       <= 1'b0;
                        r_overflow    <= 1'b0;
                        r_found_value <= '0;
                        r_found_index <= '0;
                        r_busy        <= 1'b1;
                        r_state       <= S_NEXT;
                    end
                end

                S_NEXT: begin
                    if (w_t_sum[WIDTH]) begin
                        // n and T stay at the last tested pair.
                        r_overflow    <= 1'b1;
                        r_found_value <= r_t;
                        r_found_index <= r_n;
                        r_busy        <= 1'b0;
                        r_state       <= S_OVF;
                    end else begin
                        r_n        <= w_n_inc;
                        r_t        <= w_t_sum[WIDTH-1:0];
                        r_fc_start <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end

                // fc_start is high for this state only.
                S_ISSUE: begin
                    r_state <= S_ACK;
                end

                // Let a done level left from the previous value drop first.
                S_ACK: begin
                    if (!fc_done) begin
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (fc_done) begin
                        r_count <= fc_result;
                        r_state <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (r_count > r_thr) begin
                        r_found       <= 1'b1;
                        r_found_value <= r_t;
                        r_found_index <= r_n;
                        r_busy        <= 1'b0;
                        r_state       <= S_DONE;
                    end else begin
                        r_state <= S_NEXT;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // T is only written in NEXT, so it is stable from ISSUE through CHECK.
    assign fc_value    = r_t;
    assign fc_start    = r_fc_start;
    assign busy        = r_busy;
    assign found       = r_found;
    assign found_value = r_found_value;
    assign found_index = r_found_index;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_triangle_search.sv
// -----------------------------------------------------------------------------
// tb_triangle_search
// Directed bench for triangle_search: a table of thresholds with hand-derived
// winning T(n)/n, plus sequences for reset mid-search, go while busy, restart
// from DONE/OVF and the carry-out stop (on a 16-bit instance).
// -----------------------------------------------------------------------------
module tb_triangle_search;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // 32-bit instance
    logic        go = 1'b0;
    logic [31:0] threshold = '0;
    logic        fc_start;
    logic [31:0] fc_value;
    logic        fc_done = 1'b0;
    logic [31:0] fc_result = '0;
    logic        busy, found, overflow;
    logic [31:0] found_value, found_index;

    // 16-bit instance
    logic        n_go = 1'b0;
    logic [15:0] n_threshold = '0;
    logic        n_fc_start;
    logic [15:0] n_fc_value;
    logic        n_fc_done = 1'b0;
    logic [15:0] n_fc_result = '0;
    logic        n_busy, n_found, n_overflow;
    logic [15:0] n_found_value, n_found_index;

    int tests = 0;
    int fails = 0;

    triangle_search #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .threshold(threshold),
        .fc_start(fc_start), .fc_value(fc_value), .fc_done(fc_done),
        .fc_result(fc_result), .busy(busy), .found(found),
        .found_value(found_value), .found_index(found_index),
        .overflow(overflow)
    );

    triangle_search #(.WIDTH(16)) dut_n (
        .clk(clk), .rst_n(rst_n), .go(n_go), .threshold(n_threshold),
        .fc_start(n_fc_start), .fc_value(n_fc_value), .fc_done(n_fc_done),
        .fc_result(n_fc_result), .busy(n_busy), .found(n_found),
        .found_value(n_found_value), .found_index(n_found_index),
        .overflow(n_overflow)
    );

    initial forever #5 clk = ~clk;

    function automatic int unsigned ndiv(input longint unsigned v);
        int unsigned c = 0;
        for (longint unsigned d = 1; d * d <= v; d++)
            if (v % d == 0) c += (d * d == v) ? 1 : 2;
        return c;
    endfunction

    // Behavioural divisor counters; done stays high until the next start.
    int          lat_fix = 0;
    int          lat_cnt = 0;
    logic [31:0] pend_res = '0;
    always @(posedge clk) begin
        if (fc_start) begin
            fc_done  <= 1'b0;
            lat_cnt  <= (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 20));
            pend_res <= 32'(ndiv(64'(fc_value)));
        end else if (lat_cnt > 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1) begin
                fc_done   <= 1'b1;
                fc_result <= pend_res;
            end
        end
    end

    int          n_lat = 0;
    logic [15:0] n_pend = '0;
    always @(posedge clk) begin
        if (n_fc_start) begin
            n_fc_done <= 1'b0;
            n_lat     <= 1;
            n_pend    <= 16'(ndiv(64'(n_fc_value)));
        end else if (n_lat > 0) begin
            n_lat <= n_lat - 1;
            if (n_lat == 1) begin
                n_fc_done   <= 1'b1;
                n_fc_result <= n_pend;
            end
        end
    end

    // Start-pulse monitors, sampled on the falling edge.
    logic [31:0] seen[$];
    logic        prev_start = 1'b0;
    int          n_starts = 0;
    logic [15:0] n_last = '0;
    always @(negedge clk) begin
        if (fc_start) begin
            seen.push_back(fc_value);
            tests++;
            if (prev_start) begin
                fails++;
                $display("FAIL fc_start_width: high for 2 cycles, required 1");
            end
        end
        prev_start = fc_start;
        if (n_fc_start) begin
            n_starts++;
            n_last = n_fc_value;
        end
    end

    task automatic check(input string name, input longint unsigned got,
                         input longint unsigned exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        bit ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({name, "_timeout"}, 64'(ok), 1);
    endtask

    task automatic pulse_go(input logic [31:0] thr);
        @(negedge clk);
        threshold = thr;
        go        = 1'b1;
        seen.delete();
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_starts(input int cnt, input int max_cyc);
        bit ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (seen.size() >= cnt) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("wait_start_timeout", 64'(ok), 1);
    endtask

    typedef struct {
        logic [31:0] thr;
        logic [31:0] val;
        logic [31:0] idx;
    } vec_t;

    vec_t vecs[8];

    initial begin
        bit seq_ok;

        // threshold -> first T(n) with more divisors, and its n
        vecs[0] = '{32'd0, 32'd1,   32'd1};
        vecs[1] = '{32'd1, 32'd3,   32'd2};
        vecs[2] = '{32'd2, 32'd6,   32'd3};
        vecs[3] = '{32'd3, 32'd6,   32'd3};
        vecs[4] = '{32'd5, 32'd28,  32'd7};
        vecs[5] = '{32'd4, 32'd28,  32'd7};
        vecs[6] = '{32'd6, 32'd36,  32'd8};
        vecs[7] = '{32'd9, 32'd120, 32'd15};

        // Reset state, with go held high to show reset wins.
        go = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy",        64'(busy), 0);
        check("rst_found",       64'(found), 0);
        check("rst_overflow",    64'(overflow), 0);
        check("rst_fc_start",    64'(fc_start), 0);
        check("rst_fc_value",    64'(fc_value), 0);
        check("rst_found_value", 64'(found_value), 0);
        check("rst_found_index", 64'(found_index), 0);
        go    = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table: back-to-back searches, each restarting from DONE.
        for (int v = 0; v < 8; v++) begin
            pulse_go(vecs[v].thr);
            wait_idle($sformatf("vec%0d", v), 3000);
            check($sformatf("vec%0d_found", v),       64'(found), 1);
            check($sformatf("vec%0d_overflow", v),    64'(overflow), 0);
            check($sformatf("vec%0d_found_value", v), 64'(found_value), 64'(vecs[v].val));
            check($sformatf("vec%0d_found_index", v), 64'(found_index), 64'(vecs[v].idx));
            check($sformatf("vec%0d_num_starts", v),  64'(seen.size()), 64'(vecs[v].idx));
            seq_ok = 1'b1;
            for (int i = 0; i < seen.size(); i++)
                if (seen[i] != 32'((i + 1) * (i + 2) / 2)) seq_ok = 1'b0;
            check($sformatf("vec%0d_fc_value_seq", v), 64'(seq_ok), 1);
        end

        // go during WAIT with a different threshold must be ignored.
        lat_fix = 10;
        pulse_go(32'd5);
        wait_starts(1, 200);
        repeat (2) @(negedge clk);
        threshold = 32'd0;
        go        = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_idle("go_in_wait", 3000);
        check("go_in_wait_found_value", 64'(found_value), 28);
        check("go_in_wait_found_index", 64'(found_index), 7);

        // Reset during WAIT; the late done must not restart anything.
        lat_fix = 15;
        pulse_go(32'd9);
        wait_starts(2, 400);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy",        64'(busy), 0);
        check("midrst_fc_start",    64'(fc_start), 0);
        check("midrst_fc_value",    64'(fc_value), 0);
        check("midrst_found",       64'(found), 0);
        check("midrst_found_value", 64'(found_value), 0);
        check("midrst_found_index", 64'(found_index), 0);
        check("midrst_overflow",    64'(overflow), 0);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("stale_done_level", 64'(fc_done), 1);
        check("stale_done_busy",  64'(busy), 0);
        check("stale_done_starts", 64'(seen.size()), 2);

        // Fresh search after reset, with the stale done still high.
        lat_fix = 0;
        pulse_go(32'd5);
        wait_idle("post_rst", 3000);
        check("post_rst_found_value", 64'(found_value), 28);
        check("post_rst_found_index", 64'(found_index), 7);

        // 16-bit instance: T(361)=65341 is the last value that fits.
        @(negedge clk);
        n_threshold = 16'hFFFF;
        n_go        = 1'b1;
        n_starts    = 0;
        @(negedge clk);
        n_go = 1'b0;
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 5000; i++) begin
                if (!n_busy) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check("ovf_timeout", 64'(ok), 1);
        end
        check("ovf_overflow",    64'(n_overflow), 1);
        check("ovf_found",       64'(n_found), 0);
        check("ovf_found_value", 64'(n_found_value), 65341);
        check("ovf_found_index", 64'(n_found_index), 361);
        check("ovf_num_starts",  64'(n_starts), 361);
        check("ovf_last_value",  64'(n_last), 65341);
        repeat (5) @(negedge clk);
        check("ovf_no_extra_start", 64'(n_starts), 361);

        // Restart from OVF.
        n_threshold = 16'd3;
        n_go        = 1'b1;
        @(negedge clk);
        n_go = 1'b0;
        repeat (60) @(negedge clk);
        check("ovf_restart_found",       64'(n_found), 1);
        check("ovf_restart_overflow",    64'(n_overflow), 0);
        check("ovf_restart_found_value", 64'(n_found_value), 6);
        check("ovf_restart_found_index", 64'(n_found_index), 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/triangle_search.md
TRIANGLE_SEARCH -- requirements
Module: triangle_search

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the data width of fc_value, fc_result, threshold, found_value and found_index.
REQ-002 SHALL have port clk  input  1  the single clock; all logic updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port go  input  1  start-search request, sampled only in IDLE, DONE or OVF.
REQ-005 SHALL have port threshold  input  WIDTH  the search ends at the first triangle number whose divisor count is strictly greater than this value; latched on an accepted go.
REQ-006 SHALL have port fc_start  output  1  one-cycle start pulse to the downstream divisor counter.
REQ-007 SHALL have port fc_value  output  WIDTH  the triangle number under test.
REQ-008 SHALL have port fc_done  input  1  divisor-counter completion level.
REQ-009 SHALL have port fc_result  input  WIDTH  divisor count, valid while fc_done=1.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE, DONE and OVF.
REQ-011 SHALL have port found  output  1  level, high in DONE.
REQ-012 SHALL have port found_value  output  WIDTH  the winning triangle number T(n).
REQ-013 SHALL have port found_index  output  WIDTH  the winning index n.
REQ-014 SHALL have port overflow  output  1  level, high in OVF.

Function
REQ-015 SHALL implement the states IDLE, NEXT, ISSUE, ACK, WAIT, CHECK, DONE and OVF.
REQ-016 SHALL, on an accepted go: latch threshold, set n=0 and T=0, clear found and overflow, and enter NEXT on the next cycle.
REQ-017 SHALL, in NEXT, compute n<=n+1 and T<=T+(n+1) using WIDTH+1-bit addition; if the carry-out is set, SHALL enter OVF with n and T unchanged, otherwise SHALL enter ISSUE.
REQ-018 SHALL, in ISSUE, drive fc_start=1 for exactly one cycle and then enter ACK; fc_start SHALL be 0 in every other state.
REQ-019 SHALL drive fc_value=T from ISSUE through CHECK, holding it stable for the whole divisor-counter transaction.
REQ-020 SHALL, in ACK, wait until fc_done=0 and then enter WAIT, so that a done level left over from the previous transaction is never consumed.
REQ-021 SHALL, in WAIT, wait until fc_done=1, capture fc_result, and enter CHECK; there SHALL be no timeout.
REQ-022 SHALL, in CHECK, enter DONE if the captured count is greater than the latched threshold (unsigned compare), otherwise SHALL enter NEXT.
REQ-023 SHALL, on entering DONE, load found_value=T and found_index=n, and SHALL hold found, found_value and found_index until the next accepted go or reset.
REQ-024 SHALL, in OVF, hold overflow=1; found_value and found_index SHALL hold the last value and index that were tested.
REQ-025 SHALL ignore go while busy=1.
REQ-026 SHALL, when go is asserted in DONE or OVF, restart per REQ-016.
REQ-027 SHALL test T(1)=1 as the first value.
REQ-028 SHALL give rst_n priority over go.

Reset
REQ-029 SHALL, when rst_n=0 at a clock edge, enter IDLE and clear n, T, the threshold register, fc_start, fc_value, found, found_value, found_index and overflow to 0.
REQ-030 SHALL, when reset is asserted mid-search in any state, take effect on the next edge without waiting for fc_done; any fc_done that arrives afterwards SHALL be ignored.

Verification (bench uses a behavioural divisor counter with variable latency of 1..20 cycles; its done stays high until the next start)
REQ-031 SHALL cover: threshold=5, one go pulse -> fc_value sequence 1,3,6,10,15,21,28; found=1, found_value=28, found_index=7.
REQ-032 SHALL cover: threshold=0 -> found_value=1, found_index=1, after exactly one transaction.
REQ-033 SHALL cover: threshold=3 -> found_value=6, found_index=3; a second go issued in DONE with threshold=5 -> found_value=28.
REQ-034 SHALL cover: threshold=0xFFFFFFFF -> overflow=1 after testing n=92681 (T=4294930221); no transaction for n=92682; found=0.
REQ-035 SHALL cover: rst_n pulsed low during WAIT -> the next edge gives IDLE with all outputs 0; the stale fc_done that follows leaves busy=0.
REQ-036 SHALL cover: go pulsed during WAIT -> ignored; the threshold register is unchanged and the search result is unaffected.
